dcm_prog: RTL

DCM_PROG -- requirements
Module: dcm_prog

---
 rtl/dcm_prog.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dcm_prog.sv
// Programmable dual clock divider: clk_1 at FAST_FREQ_HZ, clk_2 at FAST_FREQ_HZ/2^prog_out.
// Define DCM_PROG_SYNC_EN to pass update/prog_in through a two-stage synchronizer before capture.
module dcm_prog #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int FAST_FREQ_HZ = 10,
    parameter int PROG_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic [PROG_W-1:0] prog_in,
    output logic              clk_1,
    output logic              clk_2,
    output logic [PROG_W-1:0] prog_out,
    output logic              pending,
    output logic              tick_2
);

    localparam int HALF_CNT = CLK_FREQ_HZ / (2 * FAST_FREQ_HZ);
    localparam int PRE_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
    localparam int SLOW_W   = (1 << PROG_W) - 1;

    if (HALF_CNT < 1 || (2 * FAST_FREQ_HZ * HALF_CNT) != CLK_FREQ_HZ) begin : g_cfg_err
        $error("dcm_prog: CLK_FREQ_HZ must be a non-zero exact multiple of 2*FAST_FREQ_HZ");
    end

    logic              upd_c;
    logic [PROG_W-1:0] prog_c;

`ifdef DCM_PROG_SYNC_EN
    logic [1:0]        upd_sync_q;
    logic [PROG_W-1:0] prog_s1_q, prog_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_sync_q <= '0;
            prog_s1_q  <= '0;
            prog_s2_q  <= '0;
        end else begin
            upd_sync_q <= {upd_sync_q[0], update};
            prog_s1_q  <= prog_in;
            prog_s2_q  <= prog_s1_q;
        end
    end

    assign upd_c  = upd_sync_q[1];
    assign prog_c = prog_s2_q;
`else
    assign upd_c  = update;
    assign prog_c = prog_in;
`endif

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [SLOW_W-1:0] slow_q, slow_d;
    logic              clk1_q, clk1_d;
    logic              clk2_q, clk2_d;
    logic              tick_q, tick_d;
    logic              pend_q, pend_d;
    logic [PROG_W-1:0] pend_val_q, pend_val_d;
    logic [PROG_W-1:0] prog_q, prog_d;

    logic              half_tick;
    logic              slow_wrap;
    logic              apply;
    logic [SLOW_W:0]   slow_span;
    logic [SLOW_W-1:0] slow_lim;

    // Terminal count is 2^prog_out-1; computed one bit wider so the top exponent wraps to all-ones.
    assign slow_span = (SLOW_W + 1)'(1) << prog_q;
    assign slow_lim  = slow_span[SLOW_W-1:0] - SLOW_W'(1);
    assign half_tick = (pre_q == PRE_W'(HALF_CNT - 1));
    assign slow_wrap = half_tick && (slow_q == slow_lim);
    assign apply     = slow_wrap && clk2_q && pend_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        pre_d      = pre_q + PRE_W'(1);
        slow_d     = slow_q;
        clk1_d     = clk1_q;
        clk2_d     = clk2_q;
        tick_d     = 1'b0;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        prog_d     = prog_q;

        if (half_tick) begin
            pre_d  = '0;
            clk1_d = ~clk1_q;
            slow_d = slow_q + SLOW_W'(1);
        end

        if (slow_wrap) begin
            slow_d = '0;
            clk2_d = ~clk2_q;
            tick_d = ~clk2_q;
        end

        // Only a falling clk_2 edge closes a full slow period, so switching there never
        // truncates or stretches a period.
        if (apply) begin
            prog_d = pend_val_q;
            pend_d = 1'b0;
        end

        if (upd_c) begin
            pend_d     = 1'b1;
            pend_val_d = prog_c;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            slow_q     <= '0;
            clk1_q     <= 1'b0;
            clk2_q     <= 1'b0;
            tick_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            prog_q     <= '0;
        end else begin
            pre_q      <= pre_d;
            slow_q     <= slow_d;
            clk1_q     <= clk1_d;
            clk2_q     <= clk2_d;
            tick_q     <= tick_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            prog_q     <= prog_d;
        end
    end

    assign clk_1    = clk1_q;
    assign clk_2    = clk2_q;
    assign tick_2   = tick_q;
    assign pending  = pend_q;
    assign prog_out = prog_q;

endmodule
